i2s_transmitter: RTL

//   Stereo I2S master transmitter: accepts 24-bit left/right sample frames over a valid/ready

---
 rtl/i2s_pkg.sv | 23 ++
 rtl/i2s_bclk_gen.sv | 51 +++++
 rtl/i2s_transmitter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared types and default geometry for the I2S playback path.
// Used by i2s_bclk_gen, i2s_transmitter and their bench.
package i2s_pkg;

   localparam int I2S_DATA_WIDTH_DEF = 24;
   localparam int I2S_SLOT_WIDTH_DEF = 32;

   typedef struct packed {
      logic [I2S_DATA_WIDTH_DEF-1:0] left;
      logic [I2S_DATA_WIDTH_DEF-1:0] right;
   } i2s_frame_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } i2s_tx_state_t;

   // Counter width that stays legal for a modulus of 1.
   function automatic int cnt_width(input int modulus);
      return (modulus > 1) ? $clog2(modulus) : 1;
   endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: bclk toggles every CLK_DIV clk cycles while enabled.
// bclk_rise/bclk_fall flag the clk edge on which bclk is about to change.
module i2s_bclk_gen
   import i2s_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic bclk,
   output logic bclk_rise,
   output logic bclk_fall
);

   localparam int            CW       = cnt_width(CLK_DIV);
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] div_cnt_q, div_cnt_d;
   logic          bclk_q, bclk_d;
   logic          tick;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      tick      = en && (div_cnt_q == DIV_LAST);
      div_cnt_d = div_cnt_q;
      bclk_d    = bclk_q;
      if (tick) begin
         div_cnt_d = '0;
         bclk_d    = !bclk_q;
      end else if (en) begin
         div_cnt_d = div_cnt_q + 1'b1;
      end
   end

   // NOTE: flops take non-blocking assignments only, so every reader in the same edge sees the pre-edge value.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q <= '0;
         bclk_q    <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         bclk_q    <= bclk_d;
      end
   end

   assign bclk      = bclk_q;
   assign bclk_rise = tick && !bclk_q;
   assign bclk_fall = tick && bclk_q;

endmodule

// File: rtl/i2s_transmitter.sv
// Stereo I2S master transmitter: valid/ready frame input, one-entry holding buffer, BCLK/LRCLK/SD out.
// Build option I2S_UNDERRUN_HOLD_EN: on underrun repeat the last frame instead of sending silence.
module i2s_transmitter
   import i2s_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int DATA_WIDTH = I2S_DATA_WIDTH_DEF,
   parameter int SLOT_WIDTH = I2S_SLOT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_valid,
   output logic                  frame_ready,
   input  logic [DATA_WIDTH-1:0] left_in,
   input  logic [DATA_WIDTH-1:0] right_in,
   output logic                  i2s_bclk,
   output logic                  i2s_lrclk,
   output logic                  i2s_sd,
   output logic                  underrun
);

   localparam int            FRAME_BITS = 2 * SLOT_WIDTH;
   localparam int            KW         = $clog2(FRAME_BITS);
   localparam logic [KW-1:0] K_LAST     = KW'(FRAME_BITS - 1);
   localparam logic [KW-1:0] K_RIGHT    = KW'(SLOT_WIDTH);

   // A sample sits MSB-aligned in its slot; the trailing slot bits are zero.
   function automatic logic [SLOT_WIDTH-1:0] to_slot(input logic [DATA_WIDTH-1:0] sample);
      return SLOT_WIDTH'(sample) << (SLOT_WIDTH - DATA_WIDTH);
   endfunction

   function automatic logic [FRAME_BITS-1:0] format_frame(input logic [2*DATA_WIDTH-1:0] f);
      return {to_slot(f[2*DATA_WIDTH-1:DATA_WIDTH]), to_slot(f[DATA_WIDTH-1:0])};
   endfunction

   i2s_tx_state_t           state_q, state_d;
   logic                    buf_full_q, buf_full_d;
   logic                    ready_q, ready_d;
   logic [2*DATA_WIDTH-1:0] buf_q, buf_d;
   logic [FRAME_BITS-1:0]   shift_q, shift_d;
   logic [KW-1:0]           k_q, k_d;
   logic [KW-1:0]           k_next;
   logic                    lrclk_q, lrclk_d;
   logic                    sd_q, sd_d;
   logic                    underrun_q, underrun_d;
   logic                    accept;
`ifdef I2S_UNDERRUN_HOLD_EN
   logic [2*DATA_WIDTH-1:0] last_q, last_d;
`endif

   logic bclk;
   logic bclk_rise;
   logic bclk_fall;
   logic unused_bclk_rise;

   i2s_bclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_bclk_gen (
      .clk       (clk),
      .rst       (rst),
      .en        (state_q == RUN),
      .bclk      (bclk),
      .bclk_rise (bclk_rise),
      .bclk_fall (bclk_fall)
   );

   // The transmit side only acts on falling edges; the rise strobe serves receive-side reuse.
   assign unused_bclk_rise = bclk_rise;

   always_comb begin
      state_d    = state_q;
      buf_full_d = buf_full_q;
      buf_d      = buf_q;
      shift_d    = shift_q;
      k_d        = k_q;
      k_next     = k_q + 1'b1;
      lrclk_d    = lrclk_q;
      sd_d       = sd_q;
      underrun_d = 1'b0;
`ifdef I2S_UNDERRUN_HOLD_EN
      last_d     = last_q;
`endif

      // ready_q mirrors !buf_full_q, so an accept can never coincide with a drain.
      accept = frame_valid && ready_q;
      if (accept) begin
         buf_full_d = 1'b1;
         buf_d      = {left_in, right_in};
      end

      unique case (state_q)
         IDLE: begin
            if (buf_full_q) begin
               state_d    = RUN;
               shift_d    = format_frame(buf_q);
               buf_full_d = 1'b0;
               k_d        = '0;
               lrclk_d    = 1'b0;
               sd_d       = 1'b0;
`ifdef I2S_UNDERRUN_HOLD_EN
               last_d     = buf_q;
`endif
            end
         end
         RUN: begin
            if (bclk_fall) begin
               // Shifter MSB is the bit for the period now starting; at k=0 that is the previous right LSB.
               sd_d = shift_q[FRAME_BITS-1];
               if (k_q == K_LAST) begin
                  k_d     = '0;
                  lrclk_d = 1'b0;
                  if (buf_full_q) begin
                     shift_d    = format_frame(buf_q);
                     buf_full_d = 1'b0;
`ifdef I2S_UNDERRUN_HOLD_EN
                     last_d     = buf_q;
`endif
                  end else begin
                     underrun_d = 1'b1;
`ifdef I2S_UNDERRUN_HOLD_EN
                     shift_d    = format_frame(last_q);
`else
                     shift_d    = '0;
`endif
                  end
               end else begin
                  k_d     = k_next;
                  lrclk_d = (k_next >= K_RIGHT);
                  shift_d = shift_q << 1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      ready_d = !buf_full_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         buf_full_q <= 1'b0;
         ready_q    <= 1'b1;
         buf_q      <= '0;
         shift_q    <= '0;
         k_q        <= '0;
         lrclk_q    <= 1'b0;
         sd_q       <= 1'b0;
         underrun_q <= 1'b0;
`ifdef I2S_UNDERRUN_HOLD_EN
         last_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         buf_full_q <= buf_full_d;
         ready_q    <= ready_d;
         buf_q      <= buf_d;
         shift_q    <= shift_d;
         k_q        <= k_d;
         lrclk_q    <= lrclk_d;
         sd_q       <= sd_d;
         underrun_q <= underrun_d;
`ifdef I2S_UNDERRUN_HOLD_EN
         last_q     <= last_d;
`endif
      end
   end

   assign frame_ready = ready_q;
   assign i2s_bclk    = bclk;
   assign i2s_lrclk   = lrclk_q;
   assign i2s_sd      = sd_q;
   assign underrun    = underrun_q;

endmodule
